// File: rtl/countdown_timer_bcd_if.sv
// Control/status bundle between the menu FSM and countdown_timer_bcd.
// The optional pause level only exists when COUNTDOWN_PAUSE_EN is defined.
interface countdown_timer_bcd_if;
  logic       start;
  logic [7:0] loadVal;
  logic       cancel;
  logic       ack;
`ifdef COUNTDOWN_PAUSE_EN
  logic       pause;
`endif
  logic [8:0] seconds;
  logic       busy;
  logic       timeout;

`ifdef COUNTDOWN_PAUSE_EN
  modport master (
    output start, loadVal, cancel, ack, pause,
    input  seconds, busy, timeout
  );
  modport slave (
    input  start, loadVal, cancel, ack, pause,
    output seconds, busy, timeout
  );
`else
  modport master (
    output start, loadVal, cancel, ack,
    input  seconds, busy, timeout
  );
  modport slave (
    input  start, loadVal, cancel, ack,
    output seconds, busy, timeout
  );
`endif
endinterface

// File: rtl/countdown_timer_bcd.sv
// Per-operation BCD countdown timer feeding the 7-segment display stage.
// seconds = {active, tens, ones}; one-cycle timeout pulse when the count hits 00.
// The prescaler divides clk_i by TICK_DIV to form the decrement tick.
// Optional feature: define COUNTDOWN_PAUSE_EN to add the pause input and PAUSE state.
// reset_i is synchronous and active-low (0 = reset).
module countdown_timer_bcd #(
  parameter int TICK_DIV = 100_000_000,
  parameter int CNT_W    = 27
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  countdown_timer_bcd_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DONE  = 2'd2
`ifdef COUNTDOWN_PAUSE_EN
    ,
    PAUSE = 2'd3
`endif
  } state_t;

  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] PRESC_ONE = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] presc_q, presc_d;
  logic [8:0]       seconds_q, seconds_d;
  logic             busy_q, busy_d;
  logic             timeout_q, timeout_d;

  logic [3:0] loadTens, loadOnes;
  logic [3:0] decTens, decOnes;
  logic       pauseReq;

`ifdef COUNTDOWN_PAUSE_EN
  assign pauseReq = bus.pause;
`else
  assign pauseReq = 1'b0;
`endif

  // Clamp out-of-range load digits to 9 and form the BCD decrement of the current count
  always_comb begin
    loadTens = (bus.loadVal[7:4] > 4'd9) ? 4'd9 : bus.loadVal[7:4];
    loadOnes = (bus.loadVal[3:0] > 4'd9) ? 4'd9 : bus.loadVal[3:0];
    if (seconds_q[3:0] != 4'd0) begin
      decTens = seconds_q[7:4];
      decOnes = seconds_q[3:0] - 4'd1;
    end else if (seconds_q[7:4] != 4'd0) begin
      decTens = seconds_q[7:4] - 4'd1;
      decOnes = 4'd9;
    end else begin
      decTens = 4'd0;
      decOnes = 4'd0;
    end
  end

  // Next-state and next-output logic; priority cancel > start > ack > tick
  always_comb begin
    state_d   = state_q;
    presc_d   = presc_q;
    seconds_d = seconds_q;
    busy_d    = busy_q;
    timeout_d = 1'b0;

    if (bus.cancel) begin
      state_d   = IDLE;
      presc_d   = '0;
      seconds_d = 9'h000;
      busy_d    = 1'b0;
    end else if (bus.start) begin
      presc_d = '0;
      if (loadTens == 4'd0 && loadOnes == 4'd0) begin
        state_d   = DONE;
        seconds_d = 9'h100;
        busy_d    = 1'b0;
        timeout_d = 1'b1;
      end else begin
        state_d   = RUN;
        seconds_d = {1'b1, loadTens, loadOnes};
        busy_d    = 1'b1;
      end
    end else begin
      case (state_q)
        IDLE: begin
          seconds_d = 9'h000;
          busy_d    = 1'b0;
        end
        DONE: begin
          if (bus.ack) begin
            state_d   = IDLE;
            seconds_d = 9'h000;
          end
        end
        RUN: begin
          if (pauseReq) begin
`ifdef COUNTDOWN_PAUSE_EN
            state_d = PAUSE;
`endif
          end else if (presc_q == TICK_LAST) begin
            presc_d = '0;
            if (decTens == 4'd0 && decOnes == 4'd0) begin
              state_d   = DONE;
              seconds_d = 9'h100;
              busy_d    = 1'b0;
              timeout_d = 1'b1;
            end else begin
              seconds_d = {1'b1, decTens, decOnes};
            end
          end else begin
            presc_d = presc_q + PRESC_ONE;
          end
        end
`ifdef COUNTDOWN_PAUSE_EN
        PAUSE: begin
          if (!pauseReq) begin
            state_d = RUN;
          end
        end
`endif
        default: begin
          state_d   = IDLE;
          presc_d   = '0;
          seconds_d = 9'h000;
          busy_d    = 1'b0;
        end
      endcase
    end
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_q   <= IDLE;
      presc_q   <= '0;
      seconds_q <= 9'h000;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      seconds_q <= seconds_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.seconds = seconds_q;
  assign bus.busy    = busy_q;
  assign bus.timeout = timeout_q;

endmodule

// File: tb/tb_countdown_timer_bcd.sv
// Directed bench for countdown_timer_bcd with TICK_DIV=4.
// Each cycle pushes the expected post-edge outputs to a queue; they are popped
// and compared after the edge. Pause steps run only with COUNTDOWN_PAUSE_EN.
module tb_countdown_timer_bcd;

  typedef struct {
    string      tag;
    logic [8:0] sec;
    logic       busy;
    logic       to;
  } exp_t;

  logic clk;
  logic resetN;
  int   errors;
  int   checks;
  exp_t expQ[$];

  countdown_timer_bcd_if bus ();

  countdown_timer_bcd #(.TICK_DIV(4), .CNT_W(3)) dut (
    .clk_i   (clk),
    .reset_i (resetN),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] toBcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  // Drive one cycle of inputs and record what the outputs must be after the edge
  task automatic applyStimulus(input logic s, input logic [7:0] lv, input logic c,
                               input logic a, input string tag, input logic [8:0] sec,
                               input logic busy, input logic to);
    exp_t e;
    e.tag  = tag;
    e.sec  = sec;
    e.busy = busy;
    e.to   = to;
    expQ.push_back(e);
    bus.start   = s;
    bus.loadVal = lv;
    bus.cancel  = c;
    bus.ack     = a;
  endtask

  // Pop the oldest expectation and compare it against the registered outputs
  task automatic checkOutput();
    exp_t e;
    checks++;
    assert (expQ.size() > 0) else begin
      errors++;
      $error("[TB] FAIL scoreboard: got empty queue, want an entry");
    end
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      checks++;
      assert (bus.seconds === e.sec) else begin
        errors++;
        $error("[TB] FAIL %s seconds: got %h want %h", e.tag, bus.seconds, e.sec);
      end
      checks++;
      assert (bus.busy === e.busy) else begin
        errors++;
        $error("[TB] FAIL %s busy: got %b want %b", e.tag, bus.busy, e.busy);
      end
      checks++;
      assert (bus.timeout === e.to) else begin
        errors++;
        $error("[TB] FAIL %s timeout: got %b want %b", e.tag, bus.timeout, e.to);
      end
    end
  endtask

  task automatic cyc(input logic s, input logic [7:0] lv, input logic c, input logic a,
                     input string tag, input logic [8:0] sec, input logic busy,
                     input logic to);
    applyStimulus(s, lv, c, a, tag, sec, busy, to);
    @(posedge clk);
    #1;
    bus.start  = 1'b0;
    bus.cancel = 1'b0;
    bus.ack    = 1'b0;
    checkOutput();
  endtask

  initial begin
    errors      = 0;
    checks      = 0;
    resetN      = 1'b0;
    bus.start   = 1'b0;
    bus.loadVal = 8'h00;
    bus.cancel  = 1'b0;
    bus.ack     = 1'b0;
`ifdef COUNTDOWN_PAUSE_EN
    bus.pause   = 1'b0;
`endif
    @(posedge clk);
    #1;

    // Reset and first load/decrement
    cyc(0, 8'h00, 0, 0, "reset0", 9'h000, 0, 0);
    cyc(0, 8'h00, 0, 0, "reset1", 9'h000, 0, 0);
    resetN = 1'b1;
    cyc(0, 8'h00, 0, 0, "idle", 9'h000, 0, 0);
    cyc(1, 8'h12, 0, 0, "load12", 9'h112, 1, 0);
    for (int i = 0; i < 3; i++) cyc(0, 8'h00, 0, 0, "hold12", 9'h112, 1, 0);
    cyc(0, 8'h00, 0, 0, "dec11", 9'h111, 1, 0);

    // Full countdown from 10 through the borrow to terminal count (restart from 11)
    cyc(1, 8'h10, 0, 0, "load10", 9'h110, 1, 0);
    for (int v = 10; v >= 1; v--) begin
      for (int k = 0; k < 3; k++) cyc(0, 8'h00, 0, 0, "holdrun", {1'b1, toBcd(v)}, 1, 0);
      if (v > 1) cyc(0, 8'h00, 0, 0, "decstep", {1'b1, toBcd(v - 1)}, 1, 0);
      else       cyc(0, 8'h00, 0, 0, "terminal", 9'h100, 0, 1);
    end
    cyc(0, 8'h00, 0, 0, "donehold", 9'h100, 0, 0);
    cyc(0, 8'h00, 0, 0, "donehold2", 9'h100, 0, 0);
    cyc(0, 8'h00, 0, 1, "ackdone", 9'h000, 0, 0);
    cyc(0, 8'h00, 0, 1, "ackidle", 9'h000, 0, 0);

    // Zero load, clamping and restart while running
    cyc(1, 8'h00, 0, 0, "load00", 9'h100, 0, 1);
    cyc(0, 8'h00, 0, 0, "load00hold", 9'h100, 0, 0);
    cyc(1, 8'hA3, 0, 0, "restartdone", 9'h193, 1, 0);
    cyc(0, 8'h00, 0, 0, "hold93", 9'h193, 1, 0);
    cyc(1, 8'hFF, 0, 0, "clampFF", 9'h199, 1, 0);
    cyc(0, 8'h00, 0, 1, "ackrun", 9'h199, 1, 0);

    // Cancel paths
    cyc(1, 8'h05, 0, 0, "load05", 9'h105, 1, 0);
    cyc(0, 8'h00, 1, 0, "cancel", 9'h000, 0, 0);
    cyc(1, 8'h42, 1, 0, "startcancel", 9'h000, 0, 0);
    cyc(0, 8'h00, 0, 0, "idleaftercancel", 9'h000, 0, 0);

    // Start coincident with the terminal tick, then reset mid-count
    cyc(1, 8'h01, 0, 0, "load01", 9'h101, 1, 0);
    for (int i = 0; i < 3; i++) cyc(0, 8'h00, 0, 0, "hold01", 9'h101, 1, 0);
    cyc(1, 8'h20, 0, 0, "startonterm", 9'h120, 1, 0);
    for (int i = 0; i < 3; i++) cyc(0, 8'h00, 0, 0, "hold20", 9'h120, 1, 0);
    cyc(0, 8'h00, 0, 0, "dec19", 9'h119, 1, 0);
    resetN = 1'b0;
    cyc(0, 8'h00, 0, 0, "midreset", 9'h000, 0, 0);
    resetN = 1'b1;
    cyc(0, 8'h00, 0, 0, "postreset", 9'h000, 0, 0);

`ifdef COUNTDOWN_PAUSE_EN
    // Pause freezes the prescaler mid-period; release resumes from where it stopped
    cyc(1, 8'h08, 0, 0, "load08", 9'h108, 1, 0);
    for (int i = 0; i < 3; i++) cyc(0, 8'h00, 0, 0, "hold08", 9'h108, 1, 0);
    cyc(0, 8'h00, 0, 0, "dec07", 9'h107, 1, 0);
    cyc(0, 8'h00, 0, 0, "pre1", 9'h107, 1, 0);
    bus.pause = 1'b1;
    for (int i = 0; i < 10; i++) cyc(0, 8'h00, 0, 0, "paused", 9'h107, 1, 0);
    bus.pause = 1'b0;
    cyc(0, 8'h00, 0, 0, "resume", 9'h107, 1, 0);
    cyc(0, 8'h00, 0, 0, "resume1", 9'h107, 1, 0);
    cyc(0, 8'h00, 0, 0, "resume2", 9'h107, 1, 0);
    cyc(0, 8'h00, 0, 0, "dec06", 9'h106, 1, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
